// File: rtl/fifo_rd_seq_pkg.sv
// rtl/fifo_rd_seq_pkg.sv - shared state encoding and counter sizing for the FIFO read sequencer
package fifo_rd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HAND = 2'd1,
    DONE = 2'd2,
    GAP  = 2'd3
  } state_t;

  // Counter width able to hold 0..n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_seq_tmr.sv
// rtl/fifo_rd_seq_tmr.sv - clearable saturating up-counter with terminal-count flag
module fifo_rd_seq_tmr #(
  parameter int W  = 2,
  parameter int TC = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic run_i,
  output logic tc_o
);

  localparam logic [W-1:0] TC_V = W'(TC);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc_o = (cnt_q == TC_V);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (run_i && !tc_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_rd_seq.sv
// rtl/fifo_rd_seq.sv - async FIFO read-side sequencer feeding the TX serializer
// Optional HAND timeout with sticky error: FIFO_RD_SEQ_TO_EN
module fifo_rd_seq
  import fifo_rd_seq_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int GAP_CYC = 2,
  parameter int TO_CYC  = 64
) (
  input  logic              r_clk,
  input  logic              r_rst,
  input  logic              en,
  input  logic              r_empty,
  input  logic [DATA_W-1:0] r_data,
  output logic              r_inc,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_busy,
  output logic              seq_busy,
  output logic              to_err
);

  localparam int GAP_W  = cnt_w(GAP_CYC);
  localparam int GAP_TC = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
  localparam bit HAS_GAP = (GAP_CYC > 0);

  state_t            state_q;
  logic              r_inc_q;
  logic              tx_valid_q;
  logic              seq_busy_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              gap_tc;

  // Held at zero outside GAP, so each gap starts counting from zero.
  fifo_rd_seq_tmr #(
    .W  (GAP_W),
    .TC (GAP_TC)
  ) u_gap_tmr (
    .clk_i (r_clk),
    .rst_i (r_rst),
    .clr_i (state_q != GAP),
    .run_i (state_q == GAP),
    .tc_o  (gap_tc)
  );

`ifdef FIFO_RD_SEQ_TO_EN
  localparam int TO_W = cnt_w(TO_CYC);
  logic to_tc;
  logic to_err_q;

  // Flag fires on the HAND cycle whose edge brings the wait to TO_CYC cycles.
  fifo_rd_seq_tmr #(
    .W  (TO_W),
    .TC (TO_CYC - 1)
  ) u_to_tmr (
    .clk_i (r_clk),
    .rst_i (r_rst),
    .clr_i (state_q != HAND),
    .run_i (state_q == HAND),
    .tc_o  (to_tc)
  );

  assign to_err = to_err_q;
`else
  logic unused_to;
  assign unused_to = ^TO_CYC;
  assign to_err    = 1'b0;
`endif

  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      state_q    <= IDLE;
      r_inc_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      seq_busy_q <= 1'b0;
      tx_data_q  <= '0;
`ifdef FIFO_RD_SEQ_TO_EN
      to_err_q   <= 1'b0;
`endif
    end else begin
      r_inc_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en && !r_empty && !tx_busy) begin
            tx_data_q  <= r_data;
            r_inc_q    <= 1'b1;
            tx_valid_q <= 1'b1;
            seq_busy_q <= 1'b1;
            state_q    <= HAND;
          end
        end
        HAND: begin
          if (tx_busy) begin
            tx_valid_q <= 1'b0;
            state_q    <= DONE;
          end
`ifdef FIFO_RD_SEQ_TO_EN
          else if (to_tc) begin
            tx_valid_q <= 1'b0;
            to_err_q   <= 1'b1;
            seq_busy_q <= 1'b0;
            state_q    <= IDLE;
          end
`endif
        end
        DONE: begin
          if (!tx_busy) begin
            if (HAS_GAP) begin
              state_q <= GAP;
            end else begin
              seq_busy_q <= 1'b0;
              state_q    <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_tc) begin
            seq_busy_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign r_inc    = r_inc_q;
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign seq_busy = seq_busy_q;

endmodule

// File: tb/tb_fifo_rd_seq.sv
// tb/tb_fifo_rd_seq.sv - directed self-checking bench for fifo_rd_seq
module tb_fifo_rd_seq;

  localparam int GAP = 2;

  logic       r_clk   = 1'b0;
  logic       r_rst   = 1'b1;
  logic       en      = 1'b0;
  logic       tx_busy = 1'b0;
  logic       r_empty;
  logic [7:0] r_data;
  logic       r_inc;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       seq_busy;
  logic       to_err;

  logic [7:0] mem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int inc_cnt = 0;
  int dbl = 0;
  int empty_viol = 0;
  bit inc_prev = 1'b0;
  bit meas_sp = 1'b0;
  int last_inc = -1;
  int min_sp = 1000;
  int max_sp = 0;

  fifo_rd_seq #(
    .DATA_W  (8),
    .GAP_CYC (GAP),
    .TO_CYC  (64)
  ) dut (
    .r_clk    (r_clk),
    .r_rst    (r_rst),
    .en       (en),
    .r_empty  (r_empty),
    .r_data   (r_data),
    .r_inc    (r_inc),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_busy  (tx_busy),
    .seq_busy (seq_busy),
    .to_err   (to_err)
  );

  always #5 r_clk = ~r_clk;

  assign r_empty = (rd_ptr == wr_ptr);
  assign r_data  = mem[rd_ptr[3:0]];

  always @(posedge r_clk) begin
    cyc <= cyc + 1;
    if (r_inc && !r_empty) rd_ptr <= rd_ptr + 1;
  end

  always @(negedge r_clk) begin
    if (r_inc) begin
      inc_cnt++;
      if (r_empty) empty_viol++;
      if (inc_prev) dbl++;
      if (meas_sp) begin
        if (last_inc >= 0) begin
          if (cyc - last_inc < min_sp) min_sp = cyc - last_inc;
          if (cyc - last_inc > max_sp) max_sp = cyc - last_inc;
        end
        last_inc = cyc;
      end
    end
    inc_prev = r_inc;
  end

  task automatic push(input logic [7:0] d);
    mem[wr_ptr[3:0]] = d;
    wr_ptr++;
  endtask

  task automatic wait_valid(input logic [7:0] exp, input string name);
    int n = 0;
    while (!tx_valid && n < 100) begin
      @(negedge r_clk);
      n++;
    end
    tests++;
    if (tx_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s_valid: tx_valid=%0b expected 1 within 100 cycles", name, tx_valid);
    end else begin
      tests++;
      if (tx_data !== exp) begin
        fails++;
        $display("FAIL %s_data: tx_data=%02h expected %02h", name, tx_data, exp);
      end
      tests++;
      if (r_inc !== 1'b1) begin
        fails++;
        $display("FAIL %s_rinc: r_inc=%0b expected 1 with first tx_valid", name, r_inc);
      end
    end
  endtask

  task automatic finish_frame(input string name);
    @(negedge r_clk);
    tests++;
    if (tx_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s_hold: tx_valid=%0b expected 1 before tx_busy", name, tx_valid);
    end
    tx_busy = 1'b1;
    @(negedge r_clk);
    tests++;
    if (tx_valid !== 1'b0 || seq_busy !== 1'b1) begin
      fails++;
      $display("FAIL %s_done: tx_valid=%0b seq_busy=%0b expected 0 1", name, tx_valid, seq_busy);
    end
    repeat (9) @(negedge r_clk);
    tx_busy = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (seq_busy && n < 100) begin
      @(negedge r_clk);
      n++;
    end
    tests++;
    if (seq_busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_idle: seq_busy=%0b expected 0 within 100 cycles", name, seq_busy);
    end
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({r_inc, tx_valid, seq_busy, to_err} !== 4'b0000 || tx_data !== 8'h00) begin
      fails++;
      $display("FAIL reset: inc/valid/busy/err=%04b data=%02h expected 0000 00",
               {r_inc, tx_valid, seq_busy, to_err}, tx_data);
    end
    @(negedge r_clk);
    r_rst = 1'b0;
  endtask

  task automatic test_empty();
    int bad = 0;
    en = 1'b1;
    repeat (50) begin
      @(negedge r_clk);
      if (r_inc || tx_valid || seq_busy) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL empty: %0d active cycles expected 0", bad);
    end
  endtask

  task automatic test_three_words();
    int base = inc_cnt;
    logic [7:0] words [3];
    words[0] = 8'hA5;
    words[1] = 8'h3C;
    words[2] = 8'hFF;
    meas_sp = 1'b1;
    for (int i = 0; i < 3; i++) push(words[i]);
    for (int i = 0; i < 3; i++) begin
      wait_valid(words[i], "three");
      finish_frame("three");
    end
    wait_idle("three");
    meas_sp = 1'b0;
    tests++;
    if (inc_cnt - base != 3) begin
      fails++;
      $display("FAIL three_count: r_inc pulses=%0d expected 3", inc_cnt - base);
    end
    // busy high 1 cycle after valid for 10 cycles: 1+1+10+GAP+1 = 15 cycles between pops
    tests++;
    if (min_sp != 15 || max_sp != 15 || min_sp < 3 + GAP) begin
      fails++;
      $display("FAIL three_spacing: min=%0d max=%0d expected 15 15", min_sp, max_sp);
    end
  endtask

  task automatic test_busy_block();
    int base = inc_cnt;
    int bad = 0;
    tx_busy = 1'b1;
    push(8'h5A);
    repeat (20) begin
      @(negedge r_clk);
      if (tx_valid || r_inc) bad++;
    end
    tests++;
    if (bad != 0 || inc_cnt != base) begin
      fails++;
      $display("FAIL busy_block: active=%0d pops=%0d expected 0 0", bad, inc_cnt - base);
    end
    tx_busy = 1'b0;
    @(negedge r_clk);
    tests++;
    if (r_inc !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 8'h5A) begin
      fails++;
      $display("FAIL busy_release: r_inc=%0b tx_valid=%0b data=%02h expected 1 1 5a",
               r_inc, tx_valid, tx_data);
    end
    repeat (4) begin
      @(negedge r_clk);
      if (tx_valid !== 1'b1 || tx_data !== 8'h5A) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL busy_hold: %0d cycles without tx_valid/data expected 0", bad);
    end
    finish_frame("busy");
    wait_idle("busy");
  endtask

  task automatic test_reset_mid();
    int base = inc_cnt;
    push(8'h11);
    push(8'h22);
    wait_valid(8'h11, "rstmid1");
    @(negedge r_clk);
    tx_busy = 1'b1;
    @(negedge r_clk);
    r_rst = 1'b1;
    #1;
    tests++;
    if ({r_inc, tx_valid, seq_busy, to_err} !== 4'b0000 || tx_data !== 8'h00) begin
      fails++;
      $display("FAIL rstmid_async: inc/valid/busy/err=%04b data=%02h expected 0000 00",
               {r_inc, tx_valid, seq_busy, to_err}, tx_data);
    end
    tx_busy = 1'b0;
    @(negedge r_clk);
    r_rst = 1'b0;
    wait_valid(8'h22, "rstmid2");
    finish_frame("rstmid");
    wait_idle("rstmid");
    tests++;
    if (inc_cnt - base != 2 || !r_empty) begin
      fails++;
      $display("FAIL rstmid_pops: pops=%0d empty=%0b expected 2 1", inc_cnt - base, r_empty);
    end
  endtask

  task automatic test_en_drop();
    int base = inc_cnt;
    push(8'h77);
    push(8'h88);
    wait_valid(8'h77, "endrop");
    en = 1'b0;
    finish_frame("endrop");
    repeat (30) @(negedge r_clk);
    tests++;
    if (inc_cnt - base != 1 || tx_valid !== 1'b0 || seq_busy !== 1'b0) begin
      fails++;
      $display("FAIL endrop_park: pops=%0d valid=%0b busy=%0b expected 1 0 0",
               inc_cnt - base, tx_valid, seq_busy);
    end
    en = 1'b1;
    wait_valid(8'h88, "endrop2");
    finish_frame("endrop2");
    wait_idle("endrop2");
  endtask

`ifdef FIFO_RD_SEQ_TO_EN
  task automatic test_timeout();
    int n = 1;
    push(8'h99);
    push(8'h42);
    wait_valid(8'h99, "to");
    while (tx_valid && n < 200) begin
      @(negedge r_clk);
      if (tx_valid) n++;
    end
    tests++;
    if (n != 64) begin
      fails++;
      $display("FAIL to_cycles: tx_valid high %0d cycles expected 64", n);
    end
    tests++;
    if (to_err !== 1'b1) begin
      fails++;
      $display("FAIL to_err_set: to_err=%0b expected 1", to_err);
    end
    wait_valid(8'h42, "to_next");
    finish_frame("to_next");
    wait_idle("to_next");
    tests++;
    if (to_err !== 1'b1) begin
      fails++;
      $display("FAIL to_err_sticky: to_err=%0b expected 1", to_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_empty();
    test_three_words();
    test_busy_block();
    test_reset_mid();
    test_en_drop();
`ifdef FIFO_RD_SEQ_TO_EN
    test_timeout();
`else
    tests++;
    if (to_err !== 1'b0) begin
      fails++;
      $display("FAIL to_err_tied: to_err=%0b expected 0", to_err);
    end
`endif
    tests++;
    if (dbl != 0 || empty_viol != 0) begin
      fails++;
      $display("FAIL rinc_rules: multi-cycle=%0d while-empty=%0d expected 0 0", dbl, empty_viol);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
